// File: rtl/board_pkg.sv
// Board-level constants shared by every block on this card.
// Pure constants: no logic, no latency.
package board_pkg;
    localparam int KEYS_W        = 4;
    localparam int BOARD_CLK_MHZ = 50;
endpackage : board_pkg

// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button conditioner and its per-key slice.
// Pure declarations: no logic, no latency.
package key_pkg;
    typedef enum logic [1:0] {
        KS_RELEASED    = 2'd0,
        KS_HELD_DELAY  = 2'd1,
        KS_HELD_REPEAT = 2'd2
    } key_state_t;

    localparam int DEF_TICK_HZ             = 1000;
    localparam int DEF_DEBOUNCE_TICKS      = 10;
    localparam int DEF_REPEAT_DELAY_TICKS  = 400;
    localparam int DEF_REPEAT_PERIOD_TICKS = 100;

    // Bits needed to hold the values 0..n; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage : key_pkg

// File: rtl/key_debounce.sv
// One push-button: 2-flop sync, tick-based debounce, press/release pulses, auto-repeat FSM.
// Level follows input 2 cycles + DEBOUNCE_TICKS ticks + 1 later; pulses are one cycle, no backpressure.
module key_debounce
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW          = 1'b1,
    parameter int DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
    parameter int REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_key_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);
    localparam int DB_W = cnt_width(DEBOUNCE_TICKS);
    localparam int RP_W = cnt_width(max_int(REPEAT_DELAY_TICKS, REPEAT_PERIOD_TICKS));

    localparam logic                RAW_IDLE    = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [DB_W-1:0]     DB_SAT      = '1;
    localparam logic [RP_W-1:0]     DELAY_LAST  = RP_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [RP_W-1:0]     PERIOD_LAST = RP_W'(REPEAT_PERIOD_TICKS - 1);
    localparam logic [RP_W-1:0]     RP_SAT      = '1;

    logic             r_sync1;
    logic             r_sync2;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_repeat;
    key_state_t       r_state;
    logic [RP_W-1:0]  r_rp_cnt;

    logic             w_s;
    logic             w_differs;
    logic             w_accept;
    logic             w_acc_press;
    logic             w_acc_release;
    logic [RP_W-1:0]  w_rp_last;

    // Sync flops rest at the idle raw level so the key reads released out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= RAW_IDLE;
            r_sync2 <= RAW_IDLE;
        end else begin
            r_sync1 <= i_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s           = r_sync2 ^ ACTIVE_LOW;
    assign w_differs     = (w_s != r_level);
    assign w_accept      = w_differs && i_tick && (r_db_cnt == DB_LAST);
    assign w_acc_press   = w_accept && !r_level;
    assign w_acc_release = w_accept && r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_acc_press;
            r_release <= w_acc_release;
            if (w_accept) begin
                r_level <= ~r_level;
            end
            if (!w_differs || w_accept) begin
                r_db_cnt <= '0;
            end else if (i_tick && (r_db_cnt != DB_SAT)) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_rp_last = (r_state == KS_HELD_DELAY) ? DELAY_LAST : PERIOD_LAST;

    // Release always wins: a repeat due on the same tick as the release is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= KS_RELEASED;
            r_rp_cnt <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (w_acc_release) begin
                r_state  <= KS_RELEASED;
                r_rp_cnt <= '0;
            end else begin
                unique case (r_state)
                    KS_RELEASED: begin
                        if (w_acc_press) begin
                            r_state  <= KS_HELD_DELAY;
                            r_rp_cnt <= '0;
                        end
                    end
                    KS_HELD_DELAY, KS_HELD_REPEAT: begin
                        if (i_tick) begin
                            if (r_rp_cnt == w_rp_last) begin
                                r_repeat <= 1'b1;
                                r_state  <= KS_HELD_REPEAT;
                                r_rp_cnt <= '0;
                            end else if (r_rp_cnt != RP_SAT) begin
                                r_rp_cnt <= r_rp_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= KS_RELEASED;
                        r_rp_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;
endmodule : key_debounce

// File: rtl/strobe_gen.sv
// Divides the system clock down to a one-cycle strobe at STROBE_FREQ_HZ.
// First strobe appears DIV cycles after reset; free-running, no backpressure.
module strobe_gen #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int STROBE_FREQ_HZ = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_strobe
);
    localparam int DIV_RAW = CLK_FREQ_HZ / STROBE_FREQ_HZ;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_strobe;

    // Strobe is registered so every consumer sees a clean single-cycle pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= (r_cnt == CNT_LAST);
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_strobe = r_strobe;
endmodule : strobe_gen

// File: rtl/key_conditioner.sv
// Conditions KEYS_W raw push-buttons into debounced levels, press/release pulses and auto-repeat.
// Level lags the pin by 2 cycles + DEBOUNCE_TICKS ticks + 1; outputs are free-running, no backpressure.
module key_conditioner
    import key_pkg::*;
#(
    parameter int KEYS_W              = board_pkg::KEYS_W,
    parameter int BOARD_CLK_MHZ       = board_pkg::BOARD_CLK_MHZ,
    parameter int TICK_HZ             = DEF_TICK_HZ,
    parameter bit ACTIVE_LOW          = 1'b1,
    parameter int DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
    parameter int REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [KEYS_W-1:0] keys_raw_i,
    output logic [KEYS_W-1:0] keys_o,
    output logic [KEYS_W-1:0] press_o,
    output logic [KEYS_W-1:0] release_o,
    output logic [KEYS_W-1:0] repeat_o
);
    logic w_tick;

    strobe_gen #(
        .CLK_FREQ_HZ    (BOARD_CLK_MHZ * 1_000_000),
        .STROBE_FREQ_HZ (TICK_HZ)
    ) u_tick (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .o_strobe (w_tick)
    );

    // One shared tick keeps all keys phase-aligned; each key is otherwise independent.
    for (genvar k = 0; k < KEYS_W; k++) begin : g_key
        key_debounce #(
            .ACTIVE_LOW          (ACTIVE_LOW),
            .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
            .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
            .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS)
        ) u_key (
            .i_clk     (clk_i),
            .i_rst     (rst_i),
            .i_tick    (w_tick),
            .i_key_raw (keys_raw_i[k]),
            .o_level   (keys_o[k]),
            .o_press   (press_o[k]),
            .o_release (release_o[k]),
            .o_repeat  (repeat_o[k])
        );
    end
endmodule : key_conditioner

// File: tb/tb_key_conditioner.sv
// Directed scenarios plus a randomized run scored against a tick-arithmetic reference model.
module tb_key_conditioner;
    localparam int KW      = 3;
    localparam int CLK_MHZ = board_pkg::BOARD_CLK_MHZ;
    localparam int TICK_HZ = CLK_MHZ * 1_000_000 / 10;
    localparam int TP      = 10;
    localparam int DB      = 3;
    localparam int RD      = 5;
    localparam int RP      = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [KW-1:0] raw = '1;
    logic [KW-1:0] keys, press, rel, rpt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: edge index since reset release and per-key history.
    int            n;
    logic [KW-1:0] h1, h2;
    logic [KW-1:0] m_level, m_press, m_rel, m_rpt;
    int            run_start [KW];
    int            press_edge[KW];

    key_conditioner #(
        .KEYS_W              (KW),
        .BOARD_CLK_MHZ       (CLK_MHZ),
        .TICK_HZ             (TICK_HZ),
        .ACTIVE_LOW          (1'b1),
        .DEBOUNCE_TICKS      (DB),
        .REPEAT_DELAY_TICKS  (RD),
        .REPEAT_PERIOD_TICKS (RP)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .keys_raw_i (raw),
        .keys_o     (keys),
        .press_o    (press),
        .release_o  (rel),
        .repeat_o   (rpt)
    );

    always #5 clk = ~clk;

    // Ticks land on edges 10, 20, 30, ... after reset release; count those in [a, b].
    function automatic int ticks_in(input int a, input int b);
        return (a == 0) ? (b / TP) : (b / TP - (a - 1) / TP);
    endfunction

    task automatic model_edge();
        logic [KW-1:0] s;
        logic          tick;
        logic          was;
        int            j;
        if (rst) begin
            n = 0; h1 = '0; h2 = '0;
            m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0;
            for (int k = 0; k < KW; k++) begin
                run_start[k]  = -1;
                press_edge[k] = 0;
            end
        end else begin
            s  = h2;
            h2 = h1;
            h1 = ~raw;
            m_press = '0; m_rel = '0; m_rpt = '0;
            tick = (n > 0) && (n % TP == 0);
            for (int k = 0; k < KW; k++) begin
                was = m_level[k];
                if (s[k] == m_level[k]) begin
                    run_start[k] = -1;
                end else begin
                    if (run_start[k] < 0) run_start[k] = n;
                    if (tick && ticks_in(run_start[k], n) == DB) begin
                        m_level[k] = ~m_level[k];
                        if (m_level[k]) begin
                            m_press[k]    = 1'b1;
                            press_edge[k] = n;
                        end else begin
                            m_rel[k] = 1'b1;
                        end
                        run_start[k] = -1;
                    end
                end
                if (was && !m_rel[k] && n > press_edge[k] && ((n - press_edge[k]) % TP == 0)) begin
                    j = (n - press_edge[k]) / TP;
                    if (j >= RD && ((j - RD) % RP == 0)) m_rpt[k] = 1'b1;
                end
            end
            n++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    task automatic test_reset();
        logic [KW-1:0] seen;
        compared++;
        if ({keys, press, rel, rpt} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: outputs=%h required 0", {keys, press, rel, rpt});
        end
        rst = 1'b0;
        seen = '0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            seen |= keys | press | rel | rpt;
        end
        compared++;
        if (seen !== '0) begin
            mismatched++;
            $display("FAIL idle_after_reset: any output=%b required 000", seen);
        end
    endtask

    task automatic test_clean_press();
        int lat, npress;
        bit found, press_at_rise;
        raw[0] = 1'b0;
        lat = 0; found = 0; npress = 0; press_at_rise = 0;
        while (!found && lat < 60) begin
            cycle();
            lat++;
            if (press[0]) npress++;
            if (keys[0]) begin
                found = 1;
                press_at_rise = press[0];
            end
        end
        compared++;
        if (!found || lat < 2 + 20 || lat > 2 + 40) begin
            mismatched++;
            $display("FAIL press_latency: keys_o[0] rose after %0d cycles (found=%0d) required 22..42", lat, found);
        end
        compared++;
        if (!press_at_rise) begin
            mismatched++;
            $display("FAIL press_align: press_o[0]=0 in first keys_o[0]=1 cycle, required 1");
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (press[0]) npress++;
        end
        compared++;
        if (npress != 1) begin
            mismatched++;
            $display("FAIL press_count: %0d press_o[0] pulses, required 1", npress);
        end
        raw[0] = 1'b1;
        idle(50);
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        raw[1] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            seen |= keys[1] | press[1] | rel[1];
        end
        raw[1] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            seen |= keys[1] | press[1] | rel[1];
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch: key1 activity=%b required 0", seen);
        end
    endtask

    task automatic test_long_hold();
        int  first_rpt, prev_rpt, n_rpt, bad_gap, overlap, n_rel, rpt_after;
        bit  got, seen_rel;
        raw[0] = 1'b0;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            cycle();
            if (press[0]) got = 1;
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL hold_press: no press_o[0] within 60 cycles, required one");
        end
        first_rpt = -1; prev_rpt = -1; n_rpt = 0; bad_gap = 0; overlap = 0;
        for (int t = 1; t <= 200; t++) begin
            cycle();
            if (press[0] && rpt[0]) overlap++;
            if (rpt[0]) begin
                if (first_rpt < 0) first_rpt = t;
                else if (t - prev_rpt != 2 * TP) bad_gap++;
                prev_rpt = t;
                n_rpt++;
            end
        end
        compared++;
        if (first_rpt != RD * TP) begin
            mismatched++;
            $display("FAIL first_repeat: at %0d cycles after press, required %0d", first_rpt, RD * TP);
        end
        compared++;
        if (bad_gap != 0 || n_rpt != 8) begin
            mismatched++;
            $display("FAIL repeat_period: %0d pulses, %0d bad gaps, required 8 pulses 0 bad gaps", n_rpt, bad_gap);
        end
        compared++;
        if (overlap != 0) begin
            mismatched++;
            $display("FAIL press_repeat_overlap: %0d cycles, required 0", overlap);
        end
        raw[0] = 1'b1;
        seen_rel = 0; n_rel = 0; rpt_after = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (seen_rel && rpt[0]) rpt_after++;
            if (rel[0]) begin
                n_rel++;
                if (rpt[0]) rpt_after++;
                seen_rel = 1;
            end
        end
        compared++;
        if (n_rel != 1 || rpt_after != 0) begin
            mismatched++;
            $display("FAIL hold_release: %0d release pulses, %0d repeats after, required 1 and 0", n_rel, rpt_after);
        end
    endtask

    task automatic test_simultaneous();
        logic [KW-1:0] got;
        raw = 3'b010;
        got = '0;
        for (int i = 0; i < 60 && got == '0; i++) begin
            cycle();
            got = press;
        end
        compared++;
        if (got !== 3'b101) begin
            mismatched++;
            $display("FAIL simul_press: press_o=%b required 101", got);
        end
        raw = '1;
        got = '0;
        for (int i = 0; i < 60 && got == '0; i++) begin
            cycle();
            got = rel;
        end
        compared++;
        if (got !== 3'b101) begin
            mismatched++;
            $display("FAIL simul_release: release_o=%b required 101", got);
        end
        idle(20);
    endtask

    task automatic test_reset_mid_repeat();
        int  lat;
        bit  got;
        logic [KW-1:0] early;
        raw[0] = 1'b0;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            cycle();
            if (press[0]) got = 1;
        end
        idle(70);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        compared++;
        if ({keys, press, rel, rpt} !== '0) begin
            mismatched++;
            $display("FAIL reset_abort: outputs=%h required 0", {keys, press, rel, rpt});
        end
        lat = 0; got = 0; early = '0;
        while (!got && lat < 60) begin
            cycle();
            lat++;
            if (press[0]) got = 1;
            else early |= keys | rel | rpt | press;
        end
        compared++;
        if (!got || lat != DB * TP + 1 || early !== '0) begin
            mismatched++;
            $display("FAIL reset_repress: press after %0d cycles (found=%0d, stray=%b) required %0d", lat, got, early, DB * TP + 1);
        end
        raw[0] = 1'b1;
        idle(60);
    endtask

    task automatic test_bounce();
        int np, nr;
        np = 0; nr = 0;
        for (int t = 0; t < 12; t++) begin
            raw[2] = ~raw[2];
            for (int i = 0; i < 5; i++) begin
                cycle();
                if (press[2]) np++;
                if (rel[2]) nr++;
            end
        end
        raw[2] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (press[2]) np++;
            if (rel[2]) nr++;
        end
        compared++;
        if (np != 1 || nr != 0 || keys[2] !== 1'b1) begin
            mismatched++;
            $display("FAIL bounce: %0d presses %0d releases level=%b required 1 0 1", np, nr, keys[2]);
        end
        raw[2] = 1'b1;
        idle(50);
    endtask

    task automatic test_random();
        int hold[KW];
        int bad;
        bad = 0;
        for (int k = 0; k < KW; k++) hold[k] = $urandom_range(1, 40);
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < KW; k++) begin
                hold[k]--;
                if (hold[k] <= 0) begin
                    raw[k]  = ~raw[k];
                    hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25)
                                                          : $urandom_range(20, 140);
                end
            end
            rst = ($urandom_range(0, 699) == 0);
            cycle();
            compared++;
            if ({keys, press, rel, rpt} !== {m_level, m_press, m_rel, m_rpt}) begin
                mismatched++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle %0d: dut k/p/r/rep=%b/%b/%b/%b required %b/%b/%b/%b",
                             c, keys, press, rel, rpt, m_level, m_press, m_rel, m_rpt);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        raw = '1;
        idle(3);
        test_reset();
        test_clean_press();
        test_glitch();
        test_long_hold();
        test_simultaneous();
        test_reset_mid_repeat();
        test_bounce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule : tb_key_conditioner
